// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its
// midpoint, checks the stop bit and strobes out each good byte.
module uart_rx #(
   parameter int unsigned div_ratio = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_line,
   output logic [7:0] rx_data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CntW = $clog2(div_ratio);
   localparam logic [CntW-1:0] HalfLast = CntW'(div_ratio / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(div_ratio - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic [1:0]      sync_q;
   logic            rx_prev_q;
   logic            rx_s;
   logic            fall;

   assign rx_s = sync_q[1];
   assign fall = ~rx_s & rx_prev_q;

   // Two-flop synchroniser plus previous-sample flop for edge detection; idle is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx_line};
         rx_prev_q <= rx_s;
      end
   end

   // Receiver state, bit timing and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: every state change also clears the bit-timing counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CntW'(1);
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      busy        = 1'b1;
      case (state_q)
         StIdle: begin
            busy  = 1'b0;
            cnt_d = '0;
            if (fall) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d  = StData;
                  bitcnt_d = '0;
               end else begin
                  // Line back high at the start midpoint: a glitch, drop it silently.
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d             = '0;
               shift_d[bitcnt_q] = rx_s;
               bitcnt_d          = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  rx_data_d = shift_q;
                  valid_d   = 1'b1;
                  state_d   = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end
         end
         StBreak: begin
            // Wait out a held-low line so it reports only one error.
            cnt_d = '0;
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: begin
            busy    = 1'b0;
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   assign rx_data   = rx_data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a shuffled sweep of
// all byte values, checked against a queue of expected receive events.
module tb_uart_rx;

   localparam int unsigned DIV  = 16;
   localparam int unsigned HALF = DIV / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_line = 1'b1;
   logic [7:0] rx_data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.div_ratio(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_line   (rx_line),
      .rx_data   (rx_data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] exp_last = 8'h00;
   int         n_valid = 0;
   int         n_err = 0;
   int         last_valid_cyc = -1;
   int         prev_valid_cyc = -1;
   logic       valid_d1 = 1'b0;
   logic       ferr_d1 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void expect_byte(input logic [7:0] b);
      ev_t e;
      e.is_err = 1'b0;
      e.data   = b;
      exp_q.push_back(e);
   endfunction

   function automatic void expect_err();
      ev_t e;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      exp_q.push_back(e);
   endfunction

   // Every strobe must match the next expected event from the model.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (valid || frame_err)) begin
         check("strobe_exclusive", {31'b0, valid & frame_err}, 32'd0);
         if (valid)     check("valid_width", {31'b0, valid_d1}, 32'd0);
         if (frame_err) check("ferr_width", {31'b0, ferr_d1}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {30'b0, frame_err, valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (valid) begin
               check("strobe_kind", {31'b0, e.is_err}, 32'd0);
               check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
               exp_last       = e.data;
               prev_valid_cyc = last_valid_cyc;
               last_valid_cyc = cyc;
               n_valid++;
            end else begin
               check("strobe_kind", {31'b0, e.is_err}, 32'd1);
               check("rx_data_hold", {24'b0, rx_data}, {24'b0, exp_last});
               n_err++;
            end
         end
      end
      valid_d1 = valid;
      ferr_d1  = frame_err;
   end

   // Drive one 8N1 frame, one line value per clock; optional cut point and
   // one-cycle glitches near the start of each data bit (far from the midpoint).
   task automatic send(input logic [7:0] b, input logic stop, input int cut, input bit glitch);
      logic [9:0] fr;
      int         bi;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10 * DIV; i++) begin
         if (cut > 0 && i == cut) return;
         bi = i / DIV;
         rx_line = fr[bi];
         if (glitch && bi >= 1 && bi <= 8 && (i % DIV) == 1) rx_line = ~fr[bi];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_line = v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [7:0] perm[256];
   logic [7:0] tmp;
   int         t0;
   int         lat;
   int         k;

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_data", {24'b0, rx_data}, 32'd0);
      check("reset_valid", {31'b0, valid}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      hold(1'b1, 4);

      // Single frame and its latency from the line edge (2-3 clk sync lag).
      expect_byte(8'hA5);
      t0 = cyc;
      send(8'hA5, 1'b1, 0, 1'b0);
      hold(1'b1, DIV);
      lat = last_valid_cyc - t0;
      check("t1_count", n_valid, 32'd1);
      check("t1_latency_ok",
            {31'b0, (lat >= int'(HALF + 9 * DIV + 2)) && (lat <= int'(HALF + 9 * DIV + 3))},
            32'd1);
      check("t1_no_err", n_err, 32'd0);
      check("t1_rx_data", {24'b0, rx_data}, 32'hA5);

      // Back-to-back frames with no idle gap.
      expect_byte(8'h00);
      expect_byte(8'hFF);
      send(8'h00, 1'b1, 0, 1'b0);
      send(8'hFF, 1'b1, 0, 1'b0);
      hold(1'b1, DIV);
      check("t2_count", n_valid, 32'd3);
      check("t2_spacing", last_valid_cyc - prev_valid_cyc, 10 * DIV);
      check("t2_rx_data", {24'b0, rx_data}, 32'hFF);

      // Short low glitch: busy rises, then falls again without any strobe.
      hold(1'b0, 5);
      check("t3_busy_hi", {31'b0, busy}, 32'd1);
      rx_line = 1'b1;
      for (int i = 0; i < 8 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("t3_busy_lo", {31'b0, busy}, 32'd0);
      hold(1'b1, 2 * DIV);
      check("t3_no_valid", n_valid, 32'd3);
      check("t3_no_err", n_err, 32'd0);

      // Bad stop bit, then line held low: exactly one error, data held.
      expect_err();
      send(8'h3C, 1'b0, 0, 1'b0);
      hold(1'b0, 100);
      check("t4_err_count", n_err, 32'd1);
      check("t4_rx_data_held", {24'b0, rx_data}, 32'hFF);
      check("t4_valid_count", n_valid, 32'd3);
      hold(1'b1, 2 * DIV);
      check("t4_idle_after_release", {31'b0, busy}, 32'd0);
      expect_byte(8'h5A);
      send(8'h5A, 1'b1, 0, 1'b0);
      hold(1'b1, DIV);
      check("t4_recover_count", n_valid, 32'd4);
      check("t4_recover_data", {24'b0, rx_data}, 32'h5A);

      // Reset in the middle of data bit 4 aborts the frame at once.
      send(8'hC3, 1'b1, 5 * DIV + HALF, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_rx_data", {24'b0, rx_data}, 32'd0);
      check("t5_valid", {31'b0, valid}, 32'd0);
      check("t5_frame_err", {31'b0, frame_err}, 32'd0);
      check("t5_busy", {31'b0, busy}, 32'd0);
      rx_line = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      exp_last = 8'h00;
      hold(1'b1, 2 * DIV);
      check("t5_no_strobe", n_valid, 32'd4);
      expect_byte(8'h81);
      send(8'h81, 1'b1, 0, 1'b0);
      hold(1'b1, DIV);
      check("t5_count", n_valid, 32'd5);
      check("t5_rx_data_after", {24'b0, rx_data}, 32'h81);

      // All 256 values in shuffled order, random gaps and off-midpoint glitches.
      for (int i = 0; i < 256; i++) perm[i] = 8'(i);
      for (int j = 255; j > 0; j--) begin
         k       = int'($urandom_range(j, 0));
         tmp     = perm[j];
         perm[j] = perm[k];
         perm[k] = tmp;
      end
      for (int j = 0; j < 256; j++) begin
         expect_byte(perm[j]);
         send(perm[j], 1'b1, 0, bit'($urandom_range(1, 0)));
         hold(1'b1, int'($urandom_range(3, 0)));
      end
      hold(1'b1, 2 * DIV);
      check("t6_count", n_valid, 32'd261);
      check("t6_no_err", n_err, 32'd1);
      check("t6_pending", exp_q.size(), 32'd0);
      check("t6_last_data", {24'b0, rx_data}, {24'b0, perm[255]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
